// File: rtl/pool_pkg.sv
// ----------------------------------------------------------------------------
// pool_pkg
// Shared types and helpers for the streaming 2-D pooling stage.
//   pool_mode_t : reduction mode (POOL_MAX = 0, POOL_AVG = 1)
//   clog2       : ceiling log2, for sizing counters and address buses
//   acc_w       : accumulator width for a PW-bit pixel summed over a KxK window
//   combine     : one reduction step (max or add), evaluated at MAXW bits
// ----------------------------------------------------------------------------
package pool_pkg;

    // Widest accumulator the combine helper handles; callers extend into it.
    localparam int MAXW = 32;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A KxK sum grows by at most 2*clog2(K) bits over a single pixel.
    function automatic int acc_w(input int pw, input int k);
        return pw + 2 * clog2(k);
    endfunction

    function automatic logic signed [MAXW-1:0] combine(
        input logic signed [MAXW-1:0] a,
        input logic signed [MAXW-1:0] b,
        input pool_mode_t             m
    );
        if (m == POOL_AVG) return a + b;
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// ----------------------------------------------------------------------------
// pool_linebuf
// Holds one partially reduced value per pooled column while the rows of a
// window stream past. One combinational read port, one synchronous write port,
// both addressed by window column.
// Ports:
//   clk_i     in   clock
//   rst_ni    in   asynchronous active-low clear of every entry
//   we_i      in   write enable
//   waddr_i   in   write window column
//   wdata_i   in   write data
//   raddr_i   in   read window column
//   rdata_o   out  read data (combinational)
// ----------------------------------------------------------------------------
module pool_linebuf
    import pool_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int W     = 13,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pool2d_stream.sv
// ----------------------------------------------------------------------------
// pool2d_stream
// Streaming non-overlapping KxK pooling over a DIM_W x DIM_H raster of signed
// pixels. Each window is reduced horizontally in a single register and
// vertically through a line buffer, producing one result per window one cycle
// after its bottom-right pixel is accepted. Columns/rows beyond the last full
// window are counted but ignored.
//
// Build option: define POOL_AVG_EN to enable runtime average mode (K must be 2
// or 4). Without it the mode input is ignored and only max pooling is built.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active LOW despite the name
//   in_valid   in   pxl_in accepted this cycle
//   pxl_in     in   signed pixel, PW bits
//   mode       in   0 = max, 1 = average; captured on a frame's first pixel
//   out_valid  out  one-cycle pulse, pool_out holds a new result
//   pool_out   out  signed pooled value, PW bits
//   frame_done out  one-cycle pulse after the frame's last pixel
// ----------------------------------------------------------------------------
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DIM_W = 28,
    parameter int DIM_H = 28,
    parameter int K     = 2,
    parameter int PW    = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [PW-1:0] pxl_in,
    input  logic                 mode,
    output logic                 out_valid,
    output logic signed [PW-1:0] pool_out,
    output logic                 frame_done
);

    localparam int OW = DIM_W / K;
    localparam int OH = DIM_H / K;
`ifdef POOL_AVG_EN
    localparam int ACC   = acc_w(PW, K);
    localparam int SHIFT = 2 * clog2(K);
`else
    localparam int ACC   = PW;
`endif
    localparam int CW = clog2(DIM_W);
    localparam int RW = clog2(DIM_H);
    localparam int JW = (OW > 1) ? clog2(OW) : 1;
    localparam int KW = 2;

    if (K < 2 || K > 4 || K > DIM_W || K > DIM_H) begin : g_bad_k
        $error("pool2d_stream: K must be within 2..4 and not exceed the image size");
    end
    if (ACC > MAXW) begin : g_bad_acc
        $error("pool2d_stream: accumulator wider than the combine helper");
    end
`ifdef POOL_AVG_EN
    if (K == 3) begin : g_bad_avg_k
        $error("pool2d_stream: average mode needs K to be a power of two");
    end
`endif

    function automatic logic signed [ACC-1:0] comb_acc(
        input logic signed [ACC-1:0] a,
        input logic signed [ACC-1:0] b,
        input pool_mode_t            m
    );
        logic signed [MAXW-1:0] r;
        r = combine(MAXW'(a), MAXW'(b), m);
        return r[ACC-1:0];
    endfunction

`ifdef POOL_AVG_EN
    // Divide by K*K with floor toward minus infinity; the mean of PW-bit
    // pixels always fits back into PW bits.
    function automatic logic signed [PW-1:0] avg_scale(input logic signed [ACC-1:0] v);
        logic signed [ACC-1:0] s;
        s = v >>> SHIFT;
        return s[PW-1:0];
    endfunction
`endif

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [KW-1:0]          kcol_q, kcol_d, krow_q, krow_d;
    logic [JW-1:0]          wcol_q, wcol_d;
    logic signed [ACC-1:0]  hacc_q, hacc_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [PW-1:0]   pool_out_q, pool_out_d;
    logic                   frame_done_q, frame_done_d;

    logic                   first_px, in_crop, lb_we;
    logic signed [ACC-1:0]  px_ext, hval, vval, lb_wdata, lb_rdata;
    pool_mode_t             mode_eff;

    assign first_px = (col_q == '0) && (row_q == '0);
    assign in_crop  = ({1'b0, col_q} < (CW+1)'(OW * K)) &&
                      ({1'b0, row_q} < (RW+1)'(OH * K));

`ifdef POOL_AVG_EN
    pool_mode_t mode_q;

    // The first pixel of a frame already uses the incoming mode.
    assign mode_eff = first_px ? pool_mode_t'(mode) : mode_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= POOL_MAX;
        end else if (in_valid && first_px) begin
            mode_q <= pool_mode_t'(mode);
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign mode_eff    = POOL_MAX;
`endif

    assign px_ext = ACC'(pxl_in);
    // Window start loads the pixel as-is so all-negative windows stay negative.
    assign hval   = (kcol_q == '0) ? px_ext : comb_acc(hacc_q, px_ext, mode_eff);
    assign vval   = comb_acc(lb_rdata, hval, mode_eff);

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        kcol_d       = kcol_q;
        krow_d       = krow_q;
        wcol_d       = wcol_q;
        hacc_d       = hacc_q;
        lb_we        = 1'b0;
        lb_wdata     = hval;
        out_valid_d  = 1'b0;
        pool_out_d   = pool_out_q;
        frame_done_d = 1'b0;

        if (in_valid) begin
            if (col_q == CW'(DIM_W - 1)) begin
                col_d  = '0;
                kcol_d = '0;
                wcol_d = '0;
                if (row_q == RW'(DIM_H - 1)) begin
                    row_d        = '0;
                    krow_d       = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d  = row_q + 1'b1;
                    krow_d = (krow_q == KW'(K - 1)) ? '0 : krow_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
                if (kcol_q == KW'(K - 1)) begin
                    kcol_d = '0;
                    // Saturates on the last window so cropped columns stay in range.
                    if (wcol_q != JW'(OW - 1)) wcol_d = wcol_q + 1'b1;
                end else begin
                    kcol_d = kcol_q + 1'b1;
                end
            end

            if (in_crop) begin
                hacc_d = hval;
                if (kcol_q == KW'(K - 1)) begin
                    if (krow_q == '0) begin
                        lb_we    = 1'b1;
                        lb_wdata = hval;
                    end else if (krow_q == KW'(K - 1)) begin
                        out_valid_d = 1'b1;
`ifdef POOL_AVG_EN
                        pool_out_d  = (mode_eff == POOL_AVG) ? avg_scale(vval) : vval[PW-1:0];
`else
                        pool_out_d  = vval;
`endif
                    end else begin
                        lb_we    = 1'b1;
                        lb_wdata = vval;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            kcol_q       <= '0;
            krow_q       <= '0;
            wcol_q       <= '0;
            hacc_q       <= '0;
            out_valid_q  <= 1'b0;
            pool_out_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            kcol_q       <= kcol_d;
            krow_q       <= krow_d;
            wcol_q       <= wcol_d;
            hacc_q       <= hacc_d;
            out_valid_q  <= out_valid_d;
            pool_out_q   <= pool_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    pool_linebuf #(
        .DEPTH (OW),
        .W     (ACC),
        .AW    (JW)
    ) u_linebuf (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (lb_we),
        .waddr_i (wcol_q),
        .wdata_i (lb_wdata),
        .raddr_i (wcol_q),
        .rdata_o (lb_rdata)
    );

    assign out_valid  = out_valid_q;
    assign pool_out   = pool_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// ----------------------------------------------------------------------------
// tb_pool2d_stream
// Drives three pooling instances (4x4 K=2, 5x5 K=2, 9x6 K=4) from shared
// stimulus, one selected at a time, and compares every output cycle against
// window results computed directly from the frame held in an array.
// Average-mode scenarios are included when POOL_AVG_EN is defined.
// ----------------------------------------------------------------------------
module tb_pool2d_stream;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic signed [8:0] pxl_in;
    logic              mode;
    int                sel;

    logic              ov4, ov5, ov8, fd4, fd5, fd8;
    logic signed [8:0] po4, po5, po8;
    logic              ov, fd;
    logic signed [8:0] po;

    int n_err    = 0;
    int n_checks = 0;
    int pix [0:15][0:15];
    int got_q [$];
    int exp_q [$];

    always #5 clk = ~clk;

    pool2d_stream #(.DIM_W(4), .DIM_H(4), .K(2), .PW(9)) dut4 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid && (sel == 0)), .pxl_in(pxl_in),
        .mode(mode), .out_valid(ov4), .pool_out(po4), .frame_done(fd4));

    pool2d_stream #(.DIM_W(5), .DIM_H(5), .K(2), .PW(9)) dut5 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid && (sel == 1)), .pxl_in(pxl_in),
        .mode(mode), .out_valid(ov5), .pool_out(po5), .frame_done(fd5));

    pool2d_stream #(.DIM_W(9), .DIM_H(6), .K(4), .PW(9)) dut8 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid && (sel == 2)), .pxl_in(pxl_in),
        .mode(mode), .out_valid(ov8), .pool_out(po8), .frame_done(fd8));

    assign ov = (sel == 0) ? ov4 : (sel == 1) ? ov5 : ov8;
    assign fd = (sel == 0) ? fd4 : (sel == 1) ? fd5 : fd8;
    assign po = (sel == 0) ? po4 : (sel == 1) ? po5 : po8;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: reduce the KxK window with top-left (r0,c0) straight from the frame.
    function automatic int model_pool(input int r0, input int c0, input int k, input bit avg);
        int s, m, q;
        s = 0;
        m = pix[r0][c0];
        for (int r = r0; r < r0 + k; r++)
            for (int c = c0; c < c0 + k; c++) begin
                s += pix[r][c];
                if (pix[r][c] > m) m = pix[r][c];
            end
        if (!avg) return m;
        q = s / (k * k);
        if ((s % (k * k)) != 0 && s < 0) q--;
        return q;
    endfunction

    task automatic fill_ramp(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) pix[r][c] = r * w + c;
    endtask

    task automatic fill_const(input int w, input int h, input int v);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) pix[r][c] = v;
    endtask

    task automatic fill_random(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) pix[r][c] = int'($urandom_range(0, 511)) - 256;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        pxl_in   = 9'($urandom);
        mode     = 1'($urandom);
        @(posedge clk);
        #1;
        check_val("stall_out_valid", int'(ov), 0);
        check_val("stall_frame_done", int'(fd), 0);
    endtask

    // stall: 0 none, 1 one idle cycle before every pixel, 2 random 0..3 idle cycles.
    task automatic stream_frame(input int w, input int h, input int k, input int fmode,
                                input int stall, input int npix);
        int  n, oh, ow;
        bit  is_br, avg;
`ifdef POOL_AVG_EN
        avg = (fmode != 0);
`else
        avg = 1'b0;
`endif
        oh = h / k;
        ow = w / k;
        n  = 0;
        got_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n < npix) begin
                    if (stall == 1) idle_cycle();
                    else if (stall == 2) repeat ($urandom_range(0, 3)) idle_cycle();
                    @(negedge clk);
                    in_valid = 1'b1;
                    pxl_in   = 9'(pix[r][c]);
                    mode     = (r == 0 && c == 0) ? fmode[0] : 1'($urandom);
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                    is_br = (r < oh * k) && (c < ow * k) && (r % k == k - 1) && (c % k == k - 1);
                    check_val("out_valid", int'(ov), int'(is_br));
                    if (is_br && ov) begin
                        check_val("pool_out", int'(po), model_pool(r - k + 1, c - k + 1, k, avg));
                        got_q.push_back(int'(po));
                    end
                    check_val("frame_done", int'(fd), int'(r == h - 1 && c == w - 1));
                    n++;
                end
            end
        end
    endtask

    task automatic check_list(input string tag);
        check_val({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_val(tag, (i < got_q.size()) ? got_q[i] : -9999, exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"}, int'(ov), 0);
        check_val({tag, "_pool_out"}, int'(po), 0);
        check_val({tag, "_frame_done"}, int'(fd), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        pxl_in   = '0;
        mode     = 1'b0;
        sel      = 0;
        repeat (3) @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_reset_outputs("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 0;

        // 4x4 ramp, max
        fill_ramp(4, 4);
        stream_frame(4, 4, 2, 0, 0, 16);
        exp_q = '{5, 7, 13, 15};
        check_list("ramp_max");

        // all-negative frame must not clamp at zero
        fill_const(4, 4, -3);
        stream_frame(4, 4, 2, 0, 0, 16);
        exp_q = '{-3, -3, -3, -3};
        check_list("neg_max");

`ifdef POOL_AVG_EN
        fill_ramp(4, 4);
        stream_frame(4, 4, 2, 1, 0, 16);
        exp_q = '{2, 4, 10, 12};
        check_list("ramp_avg");

        fill_const(4, 4, 0);
        pix[0][0] = -1; pix[0][1] = -2; pix[1][0] = -2; pix[1][1] = -2;
        stream_frame(4, 4, 2, 1, 0, 16);
        exp_q = '{-2, 0, 0, 0};
        check_list("avg_floor");
`endif

        // stalled delivery gives the same sequence
        fill_ramp(4, 4);
        stream_frame(4, 4, 2, 0, 1, 16);
        exp_q = '{5, 7, 13, 15};
        check_list("ramp_alt_stall");
        stream_frame(4, 4, 2, 0, 2, 16);
        check_list("ramp_rand_stall");

        // 5x5 cropping
        sel = 1;
        fill_ramp(5, 5);
        stream_frame(5, 5, 2, 0, 0, 25);
        exp_q = '{6, 8, 16, 18};
        check_list("crop_5x5");

        // reset mid-frame after pixel 6
        sel = 0;
        fill_ramp(4, 4);
        stream_frame(4, 4, 2, 0, 0, 7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_outputs("midrst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        stream_frame(4, 4, 2, 0, 0, 16);
        exp_q = '{5, 7, 13, 15};
        check_list("after_reset");

        // random frames on every instance, back to back, random mode and stalls
        for (int it = 0; it < 9; it++) begin
            sel = it % 3;
            if (sel == 0) begin
                fill_random(4, 4);
                stream_frame(4, 4, 2, int'($urandom_range(0, 1)), 2, 16);
            end else if (sel == 1) begin
                fill_random(5, 5);
                stream_frame(5, 5, 2, int'($urandom_range(0, 1)), 2, 25);
            end else begin
                fill_random(9, 6);
                stream_frame(9, 6, 4, int'($urandom_range(0, 1)), 2, 54);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
Streaming 2-D pooling stage for the CNN datapath. Consumes one signed pixel per accepted beat in raster order and emits one pooled value per non-overlapping KxK window.
Successor to the fixed 2x2 max pool stage, with these changes:
- Parametrised image size, kernel and pixel width.
- Input valid/stall support.
- Correct handling of negative pixels.
- Runtime max/average mode.
Sits between a conv/activation stage and the next layer's input.

Parameters:
DIM_W, 28, image columns
DIM_H, 28, image rows
K, 2, kernel size and stride (non-overlapping); legal range 2..4
PW, 9, pixel width in bits, signed two's complement
OW, DIM_W/K, derived: pooled columns (floor); localparam, not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  pxl_in is accepted this cycle when high
pxl_in  in  PW  signed input pixel
mode  in  1  0 = max, 1 = average; sampled only on the frame's first accepted pixel
out_valid  out  1  one-cycle pulse: pool_out holds a new result
pool_out  out  PW  signed pooled value
frame_done  out  1  one-cycle pulse, registered with the last accepted pixel of a frame

Behaviour:
- Reset (async, active-low):
  - col, row, horizontal accumulator, line-buffer valid state, mode_q, out_valid, pool_out and frame_done are all cleared to 0.
  - Reset mid-frame discards all partial windows. The next accepted pixel is treated as (row 0, col 0).
- Counters:
  - col advances 0..DIM_W-1 on each accepted pixel and wraps to 0.
  - row advances on each col wrap, 0..DIM_H-1, then wraps to 0 (new frame).
  - Cycles with in_valid low change no state; outputs go low after one cycle.
- Cropping: pixels with col >= OW*K or row >= (DIM_H/K)*K are counted but never contribute (floor cropping).
- Horizontal reduce:
  - Register hacc. At col%K==0 it loads the pixel directly; there is no comparison against 0.
  - Otherwise it combines: max(hacc,px), or hacc+px in average mode.
- Vertical reduce:
  - Line buffer of OW entries, width ACC = PW + 2*clog2(K).
  - At col%K==K-1, the combined horizontal value for window column j = col/K is formed.
  - row%K==0: write to lbuf[j].
  - 0 < row%K < K-1: lbuf[j] = combine(lbuf[j], value).
  - row%K==K-1: final = combine(lbuf[j], value) and emit it.
- Emit:
  - out_valid=1 and pool_out registered exactly one cycle after the accepting edge of the window's bottom-right pixel.
  - Max result is a direct PW value.
  - Average result is sum >>> (2*log2 K), an arithmetic shift that floors toward minus infinity, truncated to PW (always in range).
- Mode:
  - mode_q is captured when (row,col)==(0,0) is accepted.
  - Changes to mode mid-frame are ignored until the next frame.
- frame_done: asserted one cycle after (DIM_H-1, DIM_W-1) is accepted. It can coincide with out_valid.
- Sums use ACC width internally, so there is no overflow at any K.
- Elaboration error if K<2, K>4, K>DIM_W or K>DIM_H.

Optional Feature:
POOL_AVG_EN
- Defined:
  - Average mode is available as described above.
  - Average mode requires K to be a power of two (2 or 4); otherwise elaboration error.
- Undefined:
  - The mode input is ignored and only max is synthesised.
  - The line buffer is PW wide, and K=3 is legal.

Decomposition:
- Package pool_pkg holds:
  - Typedef pool_mode_t (POOL_MAX=0, POOL_AVG=1).
  - A clog2 function.
  - ACC width function of (PW, K).
  - The combine function (max/add selected by mode).
- Sub-module pool_linebuf: OW-deep, ACC-wide register array with one read port and one write port, indexed by window column, asynchronous active-low clear.

Test Plan:
1. DIM 4x4, K=2, max, ramp 0..15 continuous -> out_valid 4 times with pool_out 5, 7, 13, 15; frame_done once, together with the 15 output.
2. DIM 4x4, K=2, max, all pixels -3 -> four outputs of -3 (never 0).
3. POOL_AVG_EN, mode=1, 4x4 ramp 0..15 -> 2, 4, 10, 12. Window {-1,-2,-2,-2} -> -2.
4. Test 1 with in_valid low on every other cycle and random bursts -> identical output sequence. Each out_valid arrives exactly one cycle after its bottom-right accept; no output occurs during stalls.
5. DIM_W=5, DIM_H=5, K=2, ramp 0..24 -> outputs 6, 8, 16, 18 only. Column 4 and row 4 are dropped; frame_done comes after pixel 24.
6. Reset asserted mid-frame after pixel 6, then a fresh 4x4 ramp -> 5, 7, 13, 15. Outputs are 0/low throughout reset. A mode toggle mid-frame has no effect until the next frame.
